match_sequencer: RTL and testbench

//   Sequences a best-of-N match: menu, per-round reset, 3-2-1 countdown, fight, round result, match result.

---
 rtl/match_sequencer.sv | 226 ++++++++++++++++++++++
 tb/tb_match_sequencer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/match_sequencer.sv
// match_sequencer: best-of-N match flow controller stepped by the 20 Hz game tick.
// Walks IDLE -> RESET_RND -> COUNTDOWN -> FIGHT -> ROUND_END -> (RESET_RND | MATCH_END),
// drives round reset / input freeze for the gameplay blocks and exports phase,
// scores and countdown digit for the renderers.
// Ports:
//   clk, reset_n       system clock, asynchronous active-low reset
//   tick               1-clk game tick strobe; all state advances only on ticks
//   start_btn          start/confirm level, must be held HOLD_TICKS ticks
//   abort_btn          abort level, held HOLD_TICKS ticks outside IDLE aborts the match
//   round_result       00 none, 01 P1 wins, 10 P2 wins, 11 draw (sampled in FIGHT only)
//   round_reset        high in IDLE and RESET_RND
//   freeze             high everywhere except FIGHT
//   phase              0 IDLE,1 RESET_RND,2 COUNTDOWN,3 FIGHT,4 ROUND_END,5 MATCH_END
//   cd_digit           countdown digit, 0 outside COUNTDOWN
//   p1_rounds/p2_rounds round wins this match
//   match_winner       00 none, 01 P1, 10 P2
module match_sequencer #(
    parameter int unsigned TICKS_PER_SEC = 20,
    parameter int unsigned COUNT_SECS    = 3,
    parameter int unsigned ROUNDS_TO_WIN = 2,
    parameter int unsigned RESULT_TICKS  = 40,
    parameter int unsigned RESET_TICKS   = 2,
    parameter int unsigned HOLD_TICKS    = 40
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       tick,
    input  logic       start_btn,
    input  logic       abort_btn,
    input  logic [1:0] round_result,
    output logic       round_reset,
    output logic       freeze,
    output logic [2:0] phase,
    output logic [1:0] cd_digit,
    output logic [1:0] p1_rounds,
    output logic [1:0] p2_rounds,
    output logic [1:0] match_winner
);

    localparam int unsigned HOLD_W  = $clog2(HOLD_TICKS + 1);
    localparam int unsigned TMR_MAX =
        (RESULT_TICKS > RESET_TICKS)
            ? ((RESULT_TICKS > TICKS_PER_SEC) ? RESULT_TICKS : TICKS_PER_SEC)
            : ((RESET_TICKS > TICKS_PER_SEC) ? RESET_TICKS : TICKS_PER_SEC);
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_RESET_RND = 3'd1;
    localparam logic [2:0] S_COUNTDOWN = 3'd2;
    localparam logic [2:0] S_FIGHT     = 3'd3;
    localparam logic [2:0] S_ROUND_END = 3'd4;
    localparam logic [2:0] S_MATCH_END = 3'd5;

    localparam logic [1:0] RES_P1   = 2'b01;
    localparam logic [1:0] RES_P2   = 2'b10;
    localparam logic [1:0] RES_DRAW = 2'b11;

    logic [2:0]        state, state_nxt;
    logic [TMR_W-1:0]  tmr, tmr_nxt;
    logic [HOLD_W-1:0] start_cnt, start_cnt_nxt;
    logic [HOLD_W-1:0] abort_cnt, abort_cnt_nxt;
    logic              start_armed, start_armed_nxt;
    logic [1:0]        cd_nxt, p1_nxt, p2_nxt, mw_nxt;
    logic              rr_nxt, fz_nxt;
    logic              start_hit, abort_hit;

    assign phase = state;

    // State and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            tmr          <= '0;
            start_cnt    <= '0;
            abort_cnt    <= '0;
            start_armed  <= 1'b1;
            cd_digit     <= 2'd0;
            p1_rounds    <= 2'd0;
            p2_rounds    <= 2'd0;
            match_winner <= 2'd0;
            round_reset  <= 1'b1;
            freeze       <= 1'b1;
        end else begin
            state        <= state_nxt;
            tmr          <= tmr_nxt;
            start_cnt    <= start_cnt_nxt;
            abort_cnt    <= abort_cnt_nxt;
            start_armed  <= start_armed_nxt;
            cd_digit     <= cd_nxt;
            p1_rounds    <= p1_nxt;
            p2_rounds    <= p2_nxt;
            match_winner <= mw_nxt;
            round_reset  <= rr_nxt;
            freeze       <= fz_nxt;
        end
    end

    // Next-state, hold counters and next outputs
    always_comb begin
        state_nxt       = state;
        tmr_nxt         = tmr;
        start_cnt_nxt   = start_cnt;
        abort_cnt_nxt   = abort_cnt;
        start_armed_nxt = start_armed;
        cd_nxt          = cd_digit;
        p1_nxt          = p1_rounds;
        p2_nxt          = p2_rounds;
        mw_nxt          = match_winner;
        start_hit       = 1'b0;
        abort_hit       = 1'b0;

        if (tick) begin
            // Start hold: only live in IDLE/MATCH_END, and only after the button has been seen released
            if (state == S_IDLE || state == S_MATCH_END) begin
                if (!start_btn) begin
                    start_cnt_nxt   = '0;
                    start_armed_nxt = 1'b1;
                end else if (start_armed && start_cnt != HOLD_W'(HOLD_TICKS)) begin
                    start_cnt_nxt = start_cnt + HOLD_W'(1);
                    start_hit     = (start_cnt == HOLD_W'(HOLD_TICKS - 1));
                end
            end else begin
                start_cnt_nxt = '0;
            end

            // Abort hold: counted only while a match is in progress
            if (state == S_IDLE || !abort_btn) begin
                abort_cnt_nxt = '0;
            end else if (abort_cnt != HOLD_W'(HOLD_TICKS)) begin
                abort_cnt_nxt = abort_cnt + HOLD_W'(1);
                abort_hit     = (abort_cnt == HOLD_W'(HOLD_TICKS - 1));
            end

            tmr_nxt = tmr + TMR_W'(1);

            case (state)
                S_IDLE: begin
                    if (start_hit) begin
                        state_nxt = S_RESET_RND;
                        tmr_nxt   = '0;
                        p1_nxt    = 2'd0;
                        p2_nxt    = 2'd0;
                        mw_nxt    = 2'd0;
                    end
                end
                S_RESET_RND: begin
                    if (tmr == TMR_W'(RESET_TICKS - 1)) begin
                        state_nxt = S_COUNTDOWN;
                        tmr_nxt   = '0;
                        cd_nxt    = 2'(COUNT_SECS);
                    end
                end
                S_COUNTDOWN: begin
                    // tmr counts ticks within the current second
                    if (tmr == TMR_W'(TICKS_PER_SEC - 1)) begin
                        tmr_nxt = '0;
                        if (cd_digit <= 2'd1) begin
                            state_nxt = S_FIGHT;
                            cd_nxt    = 2'd0;
                        end else begin
                            cd_nxt = cd_digit - 2'd1;
                        end
                    end
                end
                S_FIGHT: begin
                    tmr_nxt = '0;
                    case (round_result)
                        RES_P1: begin
                            if (p1_rounds != 2'd3) p1_nxt = p1_rounds + 2'd1;
                            state_nxt = S_ROUND_END;
                        end
                        RES_P2: begin
                            if (p2_rounds != 2'd3) p2_nxt = p2_rounds + 2'd1;
                            state_nxt = S_ROUND_END;
                        end
                        RES_DRAW: state_nxt = S_ROUND_END;
                        default:  state_nxt = S_FIGHT;
                    endcase
                end
                S_ROUND_END: begin
                    if (tmr == TMR_W'(RESULT_TICKS - 1)) begin
                        tmr_nxt = '0;
                        if (p1_rounds >= 2'(ROUNDS_TO_WIN)) begin
                            state_nxt = S_MATCH_END;
                            mw_nxt    = RES_P1;
                        end else if (p2_rounds >= 2'(ROUNDS_TO_WIN)) begin
                            state_nxt = S_MATCH_END;
                            mw_nxt    = RES_P2;
                        end else begin
                            state_nxt = S_RESET_RND;
                        end
                    end
                end
                S_MATCH_END: begin
                    if (start_hit) begin
                        state_nxt = S_IDLE;
                        p1_nxt    = 2'd0;
                        p2_nxt    = 2'd0;
                        mw_nxt    = 2'd0;
                    end
                end
                default: state_nxt = S_IDLE;
            endcase

            // Abort overrides whatever the phase logic decided this tick
            if (abort_hit) begin
                state_nxt = S_IDLE;
                tmr_nxt   = '0;
                cd_nxt    = 2'd0;
                p1_nxt    = 2'd0;
                p2_nxt    = 2'd0;
                mw_nxt    = 2'd0;
            end

            // A button still held from the previous phase must be released before it counts again
            if (state_nxt != state && (state_nxt == S_IDLE || state_nxt == S_MATCH_END)) begin
                start_cnt_nxt   = '0;
                start_armed_nxt = 1'b0;
            end
        end

        rr_nxt = (state_nxt == S_IDLE) || (state_nxt == S_RESET_RND);
        fz_nxt = (state_nxt != S_FIGHT);
    end

endmodule

// File: tb/tb_match_sequencer.sv
// tb_match_sequencer: scoreboard bench for match_sequencer. Each driven tick pushes the
// expected post-tick outputs; they are popped and compared once the tick edge has passed.
module tb_match_sequencer;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       tick;
    logic       start_btn;
    logic       abort_btn;
    logic [1:0] round_result;
    logic       round_reset;
    logic       freeze;
    logic [2:0] phase;
    logic [1:0] cd_digit;
    logic [1:0] p1_rounds;
    logic [1:0] p2_rounds;
    logic [1:0] match_winner;

    typedef struct packed {
        logic [2:0] ph;
        logic [1:0] cd;
        logic [1:0] p1;
        logic [1:0] p2;
        logic [1:0] mw;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    match_sequencer dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .tick         (tick),
        .start_btn    (start_btn),
        .abort_btn    (abort_btn),
        .round_result (round_result),
        .round_reset  (round_reset),
        .freeze       (freeze),
        .phase        (phase),
        .cd_digit     (cd_digit),
        .p1_rounds    (p1_rounds),
        .p2_rounds    (p2_rounds),
        .match_winner (match_winner)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_rst(input string tag);
        check_eq({tag, ".phase"}, 32'(phase), 32'd0);
        check_eq({tag, ".rr"},    32'(round_reset), 32'd1);
        check_eq({tag, ".fz"},    32'(freeze), 32'd1);
        check_eq({tag, ".cd"},    32'(cd_digit), 32'd0);
        check_eq({tag, ".p1"},    32'(p1_rounds), 32'd0);
        check_eq({tag, ".p2"},    32'(p2_rounds), 32'd0);
        check_eq({tag, ".mw"},    32'(match_winner), 32'd0);
    endtask

    // One game tick with the given inputs; expectation is what the outputs must show after it
    task automatic step(input string tag, input logic s, input logic a, input logic [1:0] r,
                        input logic [2:0] ph, input logic [1:0] cd, input logic [1:0] p1,
                        input logic [1:0] p2, input logic [1:0] mw);
        exp_t e;
        repeat (2) @(posedge clk);
        @(negedge clk);
        start_btn    = s;
        abort_btn    = a;
        round_result = r;
        tick         = 1'b1;
        e.ph = ph; e.cd = cd; e.p1 = p1; e.p2 = p2; e.mw = mw;
        sb.push_back(e);
        @(posedge clk);
        #1;
        tick = 1'b0;
        e = sb.pop_front();
        check_eq({tag, ".phase"}, 32'(phase), 32'(e.ph));
        check_eq({tag, ".cd"},    32'(cd_digit), 32'(e.cd));
        check_eq({tag, ".p1"},    32'(p1_rounds), 32'(e.p1));
        check_eq({tag, ".p2"},    32'(p2_rounds), 32'(e.p2));
        check_eq({tag, ".mw"},    32'(match_winner), 32'(e.mw));
        check_eq({tag, ".rr"},    32'(round_reset), 32'((e.ph == 3'd0) || (e.ph == 3'd1)));
        check_eq({tag, ".fz"},    32'(freeze), 32'(e.ph != 3'd3));
    endtask

    task automatic steps(input int n, input string tag, input logic s, input logic a,
                         input logic [1:0] r, input logic [2:0] ph, input logic [1:0] cd,
                         input logic [1:0] p1, input logic [1:0] p2, input logic [1:0] mw);
        for (int i = 0; i < n; i++) step(tag, s, a, r, ph, cd, p1, p2, mw);
    endtask

    // 60 countdown ticks: 20 per digit, the last one enters FIGHT
    task automatic countdown(input string tag, input logic s, input logic [1:0] r,
                             input logic [1:0] p1, input logic [1:0] p2);
        for (int k = 1; k <= 60; k++) begin
            if (k < 60) step(tag, s, 1'b0, r, 3'd2, 2'(3 - k / 20), p1, p2, 2'd0);
            else        step(tag, s, 1'b0, r, 3'd3, 2'd0, p1, p2, 2'd0);
        end
    endtask

    // From entry into RESET_RND through the start of FIGHT
    task automatic reset_and_count(input string tag, input logic s, input logic [1:0] r,
                                   input logic [1:0] p1, input logic [1:0] p2);
        step(tag, s, 1'b0, r, 3'd1, 2'd0, p1, p2, 2'd0);
        step(tag, s, 1'b0, r, 3'd2, 2'd3, p1, p2, 2'd0);
        countdown(tag, s, r, p1, p2);
    endtask

    // 40-tick ROUND_END banner followed by the next phase
    task automatic round_end(input string tag, input logic s, input logic [1:0] p1,
                             input logic [1:0] p2, input logic [2:0] nph, input logic [1:0] nmw);
        steps(39, tag, s, 1'b0, 2'd0, 3'd4, 2'd0, p1, p2, 2'd0);
        step(tag, s, 1'b0, 2'd0, nph, 2'd0, p1, p2, nmw);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; tick = 1'b0; start_btn = 1'b0; abort_btn = 1'b0; round_result = 2'd0;
        repeat (3) @(posedge clk);
        #1;
        check_rst("reset");
        @(negedge clk);
        reset_n = 1'b1;

        // Held button without ticks must not count
        start_btn = 1'b1;
        repeat (50) @(posedge clk);
        #1;
        check_eq("no_tick.phase", 32'(phase), 32'd0);

        // Match 1: P1 round, draw replay, short abort hold, P1 round -> MATCH_END
        steps(39, "m1_hold", 1'b1, 1'b0, 2'd0, 3'd0, 2'd0, 2'd0, 2'd0, 2'd0);
        step("m1_start", 1'b1, 1'b0, 2'd0, 3'd1, 2'd0, 2'd0, 2'd0, 2'd0);
        reset_and_count("m1_r1", 1'b0, 2'b01, 2'd0, 2'd0);
        step("m1_win1", 1'b0, 1'b0, 2'b01, 3'd4, 2'd0, 2'd1, 2'd0, 2'd0);
        round_end("m1_re1", 1'b0, 2'd1, 2'd0, 3'd1, 2'd0);
        reset_and_count("m1_r2", 1'b0, 2'd0, 2'd1, 2'd0);
        steps(3, "m1_fight", 1'b0, 1'b0, 2'd0, 3'd3, 2'd0, 2'd1, 2'd0, 2'd0);
        step("m1_draw", 1'b0, 1'b0, 2'b11, 3'd4, 2'd0, 2'd1, 2'd0, 2'd0);
        round_end("m1_re2", 1'b0, 2'd1, 2'd0, 3'd1, 2'd0);
        reset_and_count("m1_r3", 1'b0, 2'd0, 2'd1, 2'd0);
        steps(39, "m1_ab39", 1'b0, 1'b1, 2'd0, 3'd3, 2'd0, 2'd1, 2'd0, 2'd0);
        step("m1_abrel", 1'b0, 1'b0, 2'd0, 3'd3, 2'd0, 2'd1, 2'd0, 2'd0);
        step("m1_win2", 1'b0, 1'b0, 2'b01, 3'd4, 2'd0, 2'd2, 2'd0, 2'd0);
        round_end("m1_re3", 1'b0, 2'd2, 2'd0, 3'd5, 2'b01);
        steps(3, "m1_mend", 1'b0, 1'b0, 2'd0, 3'd5, 2'd0, 2'd2, 2'd0, 2'b01);
        steps(39, "m1_mhold", 1'b1, 1'b0, 2'd0, 3'd5, 2'd0, 2'd2, 2'd0, 2'b01);
        step("m1_toidle", 1'b1, 1'b0, 2'd0, 3'd0, 2'd0, 2'd0, 2'd0, 2'd0);

        // Still-held start after entering IDLE must not retrigger
        steps(45, "idle_stuck", 1'b1, 1'b0, 2'd0, 3'd0, 2'd0, 2'd0, 2'd0, 2'd0);
        step("idle_rel", 1'b0, 1'b0, 2'd0, 3'd0, 2'd0, 2'd0, 2'd0, 2'd0);

        // Match 2: P2 round, then abort completing on a tick with a P2 result
        steps(39, "m2_hold", 1'b1, 1'b0, 2'd0, 3'd0, 2'd0, 2'd0, 2'd0, 2'd0);
        step("m2_start", 1'b1, 1'b0, 2'd0, 3'd1, 2'd0, 2'd0, 2'd0, 2'd0);
        reset_and_count("m2_r1", 1'b0, 2'd0, 2'd0, 2'd0);
        step("m2_win1", 1'b0, 1'b0, 2'b10, 3'd4, 2'd0, 2'd0, 2'd1, 2'd0);
        round_end("m2_re1", 1'b0, 2'd0, 2'd1, 3'd1, 2'd0);
        reset_and_count("m2_r2", 1'b0, 2'd0, 2'd0, 2'd1);
        steps(39, "m2_ab", 1'b0, 1'b1, 2'd0, 3'd3, 2'd0, 2'd0, 2'd1, 2'd0);
        step("m2_abort", 1'b0, 1'b1, 2'b10, 3'd0, 2'd0, 2'd0, 2'd0, 2'd0);
        step("m2_idle", 1'b0, 1'b0, 2'd0, 3'd0, 2'd0, 2'd0, 2'd0, 2'd0);

        // Match 3: start held from IDLE all the way into MATCH_END
        steps(39, "m3_hold", 1'b1, 1'b0, 2'd0, 3'd0, 2'd0, 2'd0, 2'd0, 2'd0);
        step("m3_start", 1'b1, 1'b0, 2'd0, 3'd1, 2'd0, 2'd0, 2'd0, 2'd0);
        reset_and_count("m3_r1", 1'b1, 2'd0, 2'd0, 2'd0);
        step("m3_win1", 1'b1, 1'b0, 2'b10, 3'd4, 2'd0, 2'd0, 2'd1, 2'd0);
        round_end("m3_re1", 1'b1, 2'd0, 2'd1, 3'd1, 2'd0);
        reset_and_count("m3_r2", 1'b1, 2'd0, 2'd0, 2'd1);
        step("m3_win2", 1'b1, 1'b0, 2'b10, 3'd4, 2'd0, 2'd0, 2'd2, 2'd0);
        round_end("m3_re2", 1'b1, 2'd0, 2'd2, 3'd5, 2'b10);
        steps(50, "m3_stuck", 1'b1, 1'b0, 2'd0, 3'd5, 2'd0, 2'd0, 2'd2, 2'b10);
        step("m3_rel", 1'b0, 1'b0, 2'd0, 3'd5, 2'd0, 2'd0, 2'd2, 2'b10);
        steps(39, "m3_mhold", 1'b1, 1'b0, 2'd0, 3'd5, 2'd0, 2'd0, 2'd2, 2'b10);
        step("m3_toidle", 1'b1, 1'b0, 2'd0, 3'd0, 2'd0, 2'd0, 2'd0, 2'd0);
        step("m3_idle", 1'b0, 1'b0, 2'd0, 3'd0, 2'd0, 2'd0, 2'd0, 2'd0);

        // Async reset in the middle of COUNTDOWN, between ticks
        steps(39, "m4_hold", 1'b1, 1'b0, 2'd0, 3'd0, 2'd0, 2'd0, 2'd0, 2'd0);
        step("m4_start", 1'b1, 1'b0, 2'd0, 3'd1, 2'd0, 2'd0, 2'd0, 2'd0);
        step("m4_rst", 1'b0, 1'b0, 2'd0, 3'd1, 2'd0, 2'd0, 2'd0, 2'd0);
        step("m4_cd", 1'b0, 1'b0, 2'd0, 3'd2, 2'd3, 2'd0, 2'd0, 2'd0);
        for (int k = 1; k <= 25; k++)
            step("m4_cdrun", 1'b0, 1'b0, 2'd0, 3'd2, 2'(3 - k / 20), 2'd0, 2'd0, 2'd0);
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check_rst("async_rst");
        @(negedge clk);
        reset_n = 1'b1;

        // Fresh start after reset needs a full 40-tick hold again
        steps(39, "m5_hold", 1'b1, 1'b0, 2'd0, 3'd0, 2'd0, 2'd0, 2'd0, 2'd0);
        step("m5_start", 1'b1, 1'b0, 2'd0, 3'd1, 2'd0, 2'd0, 2'd0, 2'd0);

        check_eq("sb_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
